bulk_in_arbiter: RTL and testbench



---
 rtl/bulk_in_arbiter.sv | 153 +++++++++++++++
 tb/tb_bulk_in_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bulk_in_arbiter.sv
// Shares the single bulk-IN data path among three IN endpoint sources.
// On each token it reports readiness, locks onto one source per packet and cuts packets at MAX_PACKET.
module bulk_in_arbiter #(
  parameter logic [3:0]  ENDPOINT1  = 4'd1,
  parameter logic [3:0]  ENDPOINT2  = 4'd2,
  parameter logic [3:0]  ENDPOINT3  = 4'd3,
  parameter int unsigned MAX_PACKET = 512
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  tok_endp_i,
  input  logic [2:0]  src_ready_i,
  output logic        blk_in_ready_o,
  input  logic        blk_start_i,
  input  logic        blk_cycle_i,
  input  logic [3:0]  blk_endpt_i,
  input  logic        blk_error_i,
  input  logic [2:0]  s_tvalid_i,
  output logic [2:0]  s_tready_o,
  input  logic [2:0]  s_tlast_i,
  input  logic [23:0] s_tdata_i,
  output logic        m_tvalid_o,
  input  logic        m_tready_i,
  output logic        m_tlast_o,
  output logic [7:0]  m_tdata_o,
  output logic [1:0]  sel_o,
  output logic        overrun_o
);

  localparam int unsigned CW       = $clog2(MAX_PACKET);
  localparam logic [1:0]  SEL_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_NULL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sel;
  logic [CW-1:0]   r_count;
  logic            r_in_ready;
  logic            r_overrun;

  logic [1:0]      w_tok_src;
  logic [1:0]      w_blk_src;
  logic [3:0]      w_srdy4;
  logic [3:0]      w_tvalid4;
  logic [3:0]      w_tlast4;
  logic [31:0]     w_tdata4;
  logic [3:0]      w_tready4;
  logic            w_m_tvalid;
  logic            w_m_tlast;
  logic [7:0]      w_m_tdata;
  logic            w_cnt_max;
  logic            w_beat;
  logic            w_forced_cut;
  logic            w_abort;

  // Lowest source index wins if endpoint parameters collide; 3 means no source.
  function automatic logic [1:0] match_src(input logic [3:0] endp);
    if (endp == ENDPOINT1)      return 2'd0;
    else if (endp == ENDPOINT2) return 2'd1;
    else if (endp == ENDPOINT3) return 2'd2;
    else                        return SEL_NONE;
  endfunction

  assign w_tok_src = match_src(tok_endp_i);
  assign w_blk_src = match_src(blk_endpt_i);

  // Pad to four entries so index 3 (no source) reads as idle.
  assign w_srdy4   = {1'b0, src_ready_i};
  assign w_tvalid4 = {1'b0, s_tvalid_i};
  assign w_tlast4  = {1'b0, s_tlast_i};
  assign w_tdata4  = {8'h00, s_tdata_i};

  assign w_cnt_max = (r_count == CW'(MAX_PACKET - 1));

  // Combinational routing of the selected source; closed outside XFER.
  always_comb begin : datapath
    w_tready4  = 4'b0000;
    w_m_tvalid = 1'b0;
    w_m_tlast  = 1'b0;
    w_m_tdata  = 8'h00;
    if (r_state == ST_XFER) begin
      w_m_tvalid       = w_tvalid4[r_sel];
      w_tready4[r_sel] = m_tready_i;
      w_m_tdata        = w_tdata4[{r_sel, 3'b000} +: 8];
      w_m_tlast        = w_tlast4[r_sel] | w_cnt_max;
    end
  end

  assign w_beat       = w_m_tvalid & m_tready_i;
  assign w_forced_cut = w_cnt_max & ~w_tlast4[r_sel];
  assign w_abort      = blk_error_i | ~blk_cycle_i;

  assign m_tvalid_o = w_m_tvalid;
  assign m_tlast_o  = w_m_tlast;
  assign m_tdata_o  = w_m_tdata;
  assign s_tready_o = w_tready4[2:0];

  // Packet scheduler: abort beats a final beat, start is honoured only in IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= SEL_NONE;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_in_ready <= w_srdy4[w_tok_src];
      case (r_state)
        ST_IDLE: begin
          if (blk_error_i) begin
            r_sel   <= SEL_NONE;
            r_count <= '0;
          end else if (blk_start_i) begin
            r_sel   <= w_blk_src;
            r_count <= '0;
            r_state <= (w_blk_src == SEL_NONE) ? ST_NULL : ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_NONE;
            r_count <= '0;
          end else if (w_beat) begin
            if (w_m_tlast) begin
              r_state <= ST_DONE;
              if (w_forced_cut) r_overrun <= 1'b1;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
        default: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_NONE;
            r_count <= '0;
          end
        end
      endcase
    end
  end

  assign blk_in_ready_o = r_in_ready;
  assign sel_o          = r_sel;
  assign overrun_o      = r_overrun;

endmodule

// File: tb/tb_bulk_in_arbiter.sv
// Bench for bulk_in_arbiter: readiness table, directed packet/abort/null/reset sequences,
// and randomized transactions checked against per-source byte queues split into packets.
module tb_bulk_in_arbiter;

  localparam int unsigned MAXP = 512;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  tok_endp_i;
  logic [2:0]  src_ready_i;
  logic        blk_in_ready_o;
  logic        blk_start_i;
  logic        blk_cycle_i;
  logic [3:0]  blk_endpt_i;
  logic        blk_error_i;
  logic [2:0]  s_tvalid_i;
  logic [2:0]  s_tready_o;
  logic [2:0]  s_tlast_i;
  logic [23:0] s_tdata_i;
  logic        m_tvalid_o;
  logic        m_tready_i;
  logic        m_tlast_o;
  logic [7:0]  m_tdata_o;
  logic [1:0]  sel_o;
  logic        overrun_o;

  bulk_in_arbiter #(
    .ENDPOINT1 (4'd1),
    .ENDPOINT2 (4'd2),
    .ENDPOINT3 (4'd3),
    .MAX_PACKET(MAXP)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .tok_endp_i    (tok_endp_i),
    .src_ready_i   (src_ready_i),
    .blk_in_ready_o(blk_in_ready_o),
    .blk_start_i   (blk_start_i),
    .blk_cycle_i   (blk_cycle_i),
    .blk_endpt_i   (blk_endpt_i),
    .blk_error_i   (blk_error_i),
    .s_tvalid_i    (s_tvalid_i),
    .s_tready_o    (s_tready_o),
    .s_tlast_i     (s_tlast_i),
    .s_tdata_i     (s_tdata_i),
    .m_tvalid_o    (m_tvalid_o),
    .m_tready_i    (m_tready_i),
    .m_tlast_o     (m_tlast_o),
    .m_tdata_o     (m_tdata_o),
    .sel_o         (sel_o),
    .overrun_o     (overrun_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Per-source byte streams: {last, data}; front entry is what the source presents.
  logic [8:0] srcq [3][$];

  typedef struct {
    logic [3:0] tok;
    logic [2:0] rdy;
    logic       exp;
  } tok_vec_t;

  tok_vec_t tv [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_srcs(input int vprob);
    for (int i = 0; i < 3; i++) begin
      if (srcq[i].size() > 0 && int'($urandom_range(99)) < vprob) begin
        s_tvalid_i[i]       = 1'b1;
        s_tdata_i[8*i +: 8] = srcq[i][0][7:0];
        s_tlast_i[i]        = srcq[i][0][8];
      end else begin
        s_tvalid_i[i]       = 1'b0;
        s_tdata_i[8*i +: 8] = 8'($urandom);
        s_tlast_i[i]        = 1'($urandom);
      end
    end
  endtask

  task automatic push_pkt(input int src, input int len, input bit with_last, input logic [7:0] base);
    for (int k = 0; k < len; k++)
      srcq[src].push_back({(with_last && k == len - 1), 8'(int'(base) + k)});
  endtask

  // One bulk cycle on endpoint ep expected to route source src; abort_after>0 aborts after that many beats.
  task automatic run_xfer(input logic [3:0] ep, input int src, input int vprob,
                          input int abort_after, output int nbeats);
    logic       tv0;
    logic       beat;
    logic       exp_last;
    logic [2:0] exp_tready;
    bit         done;
    int         budget;
    nbeats      = 0;
    done        = 0;
    budget      = 0;
    blk_cycle_i = 1'b1;
    blk_start_i = 1'b1;
    blk_endpt_i = ep;
    blk_error_i = 1'b0;
    m_tready_i  = 1'b1;
    drive_srcs(vprob);
    #1;
    chk("start_cycle_tvalid", 32'(m_tvalid_o), 0);
    chk("start_cycle_tready", 32'(s_tready_o), 0);
    tick();
    blk_start_i = 1'b0;
    while (!done) begin
      drive_srcs(vprob);
      m_tready_i = 1'b0;
      #1;
      tv0 = m_tvalid_o;
      m_tready_i = ($urandom_range(99) < 70);
      #1;
      chk("tvalid_vs_tready", 32'(m_tvalid_o), 32'(tv0));
      chk("xfer_sel", 32'(sel_o), 32'(src));
      chk("xfer_tvalid", 32'(m_tvalid_o), 32'(s_tvalid_i[src]));
      exp_tready      = 3'b000;
      exp_tready[src] = m_tready_i;
      chk("xfer_s_tready", 32'(s_tready_o), 32'(exp_tready));
      beat = m_tvalid_o & m_tready_i;
      if (beat) begin
        if (srcq[src].size() == 0) begin
          chk("beat_from_empty_source", 1, 0);
          done = 1;
        end else begin
          exp_last = srcq[src][0][8] | (nbeats == MAXP - 1);
          chk("beat_tdata", 32'(m_tdata_o), 32'(srcq[src][0][7:0]));
          chk("beat_tlast", 32'(m_tlast_o), 32'(exp_last));
          nbeats++;
          if (exp_last) done = 1;
        end
      end
      tick();
      if (beat && srcq[src].size() > 0) void'(srcq[src].pop_front());
      if (!done && abort_after > 0 && nbeats == abort_after) begin
        blk_error_i = 1'b1;
        m_tready_i  = 1'b0;
        drive_srcs(100);
        tick();
        blk_error_i = 1'b0;
        m_tready_i  = 1'b1;
        drive_srcs(100);
        #1;
        chk("abort_tvalid", 32'(m_tvalid_o), 0);
        chk("abort_sel", 32'(sel_o), 3);
        chk("abort_s_tready", 32'(s_tready_o), 0);
        blk_cycle_i = 1'b0;
        tick();
        return;
      end
      budget++;
      if (budget > 4000) begin
        chk("xfer_timeout", 1, 0);
        done = 1;
      end
    end
    drive_srcs(100);
    m_tready_i = 1'b1;
    #1;
    chk("done_tvalid", 32'(m_tvalid_o), 0);
    chk("done_s_tready", 32'(s_tready_o), 0);
    blk_cycle_i = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    tv[0] = '{4'd2,  3'b010, 1'b1};
    tv[1] = '{4'd2,  3'b000, 1'b0};
    tv[2] = '{4'd9,  3'b111, 1'b0};
    tv[3] = '{4'd1,  3'b001, 1'b1};
    tv[4] = '{4'd1,  3'b110, 1'b0};
    tv[5] = '{4'd3,  3'b100, 1'b1};
    tv[6] = '{4'd3,  3'b011, 1'b0};
    tv[7] = '{4'd0,  3'b111, 1'b0};
    tv[8] = '{4'd15, 3'b111, 1'b0};
    tv[9] = '{4'd2,  3'b101, 1'b0};

    reset_n     = 1'b0;
    tok_endp_i  = 4'd0;
    src_ready_i = 3'b000;
    blk_start_i = 1'b0;
    blk_cycle_i = 1'b0;
    blk_endpt_i = 4'd0;
    blk_error_i = 1'b0;
    s_tvalid_i  = 3'b000;
    s_tlast_i   = 3'b000;
    s_tdata_i   = 24'h0;
    m_tready_i  = 1'b0;
    #12;
    chk("rst_in_ready", 32'(blk_in_ready_o), 0);
    chk("rst_s_tready", 32'(s_tready_o), 0);
    chk("rst_tvalid", 32'(m_tvalid_o), 0);
    chk("rst_tlast", 32'(m_tlast_o), 0);
    chk("rst_tdata", 32'(m_tdata_o), 0);
    chk("rst_sel", 32'(sel_o), 3);
    chk("rst_overrun", 32'(overrun_o), 0);
    reset_n = 1'b1;
    tick();

    // Readiness follows the token with one cycle of latency.
    tok_endp_i  = 4'd2;
    src_ready_i = 3'b010;
    #1;
    chk("ready_latency_before", 32'(blk_in_ready_o), 0);
    tick();
    chk("ready_ep2_up", 32'(blk_in_ready_o), 1);
    src_ready_i = 3'b000;
    #1;
    chk("ready_hold_until_edge", 32'(blk_in_ready_o), 1);
    tick();
    chk("ready_ep2_down", 32'(blk_in_ready_o), 0);
    for (int i = 0; i < 10; i++) begin
      tok_endp_i  = tv[i].tok;
      src_ready_i = tv[i].rdy;
      tick();
      chk($sformatf("ready_vec%0d", i), 32'(blk_in_ready_o), 32'(tv[i].exp));
    end

    // Five-byte source-0 packet 01..05.
    push_pkt(0, 5, 1, 8'h01);
    push_pkt(1, 4, 1, 8'h40);
    push_pkt(2, 4, 1, 8'h80);
    run_xfer(4'd1, 0, 100, 0, n);
    chk("pkt5_beats", 32'(n), 5);
    chk("pkt5_overrun", 32'(overrun_o), 0);

    // Unmatched endpoint: no routing, start ignored while in NULL.
    blk_cycle_i = 1'b1;
    blk_start_i = 1'b1;
    blk_endpt_i = 4'd7;
    tick();
    blk_start_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_srcs(100);
      m_tready_i  = 1'b1;
      blk_start_i = (c == 0);
      blk_endpt_i = 4'd1;
      #1;
      chk("null_tvalid", 32'(m_tvalid_o), 0);
      chk("null_s_tready", 32'(s_tready_o), 0);
      chk("null_sel", 32'(sel_o), 3);
      tick();
    end
    blk_start_i = 1'b0;
    blk_cycle_i = 1'b0;
    tick();
    drive_srcs(100);
    #1;
    chk("null_exit_tvalid", 32'(m_tvalid_o), 0);
    tick();

    // Randomized short packets on random sources.
    for (int t = 0; t < 30; t++) begin
      int src;
      src = int'($urandom_range(2));
      push_pkt(src, int'($urandom_range(1, 40)), 1, 8'($urandom));
      run_xfer(4'(src + 1), src, int'($urandom_range(60, 100)), 0, n);
    end
    chk("rand_overrun", 32'(overrun_o), 0);
    for (int i = 0; i < 3; i++) srcq[i].delete();

    // Abort after 3 beats, then source 2 on EP3, then source 0 resumes.
    push_pkt(0, 64, 1, 8'h10);
    run_xfer(4'd1, 0, 100, 3, n);
    chk("abort_beats", 32'(n), 3);
    push_pkt(2, 20, 1, 8'hA0);
    run_xfer(4'd3, 2, 100, 0, n);
    chk("after_abort_ep3_beats", 32'(n), 20);
    run_xfer(4'd1, 0, 100, 0, n);
    chk("resume_src0_beats", 32'(n), 61);

    // 700 bytes without an early tlast: cut at 512, remainder in next packet.
    push_pkt(1, 700, 1, 8'h01);
    run_xfer(4'd2, 1, 100, 0, n);
    chk("cut_beats", 32'(n), 512);
    chk("cut_overrun", 32'(overrun_o), 1);
    run_xfer(4'd2, 1, 100, 0, n);
    chk("cut_rest_beats", 32'(n), 188);

    // Count restarts from zero after an abort.
    push_pkt(1, 700, 1, 8'h33);
    run_xfer(4'd2, 1, 100, 100, n);
    chk("abort100_beats", 32'(n), 100);
    run_xfer(4'd2, 1, 100, 0, n);
    chk("post_abort_cut_beats", 32'(n), 512);
    run_xfer(4'd2, 1, 100, 0, n);
    chk("post_abort_rest_beats", 32'(n), 88);
    chk("queues_drained", 32'(srcq[0].size() + srcq[1].size() + srcq[2].size()), 0);

    // Asynchronous reset in the middle of a packet.
    push_pkt(0, 20, 1, 8'h55);
    tok_endp_i  = 4'd1;
    src_ready_i = 3'b001;
    blk_cycle_i = 1'b1;
    blk_start_i = 1'b1;
    blk_endpt_i = 4'd1;
    drive_srcs(100);
    tick();
    blk_start_i = 1'b0;
    m_tready_i  = 1'b1;
    drive_srcs(100);
    tick();
    drive_srcs(100);
    #1;
    chk("pre_rst_tvalid", 32'(m_tvalid_o), 1);
    chk("pre_rst_in_ready", 32'(blk_in_ready_o), 1);
    chk("pre_rst_overrun", 32'(overrun_o), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_tvalid", 32'(m_tvalid_o), 0);
    chk("async_rst_s_tready", 32'(s_tready_o), 0);
    chk("async_rst_tlast", 32'(m_tlast_o), 0);
    chk("async_rst_tdata", 32'(m_tdata_o), 0);
    chk("async_rst_sel", 32'(sel_o), 3);
    chk("async_rst_overrun", 32'(overrun_o), 0);
    chk("async_rst_in_ready", 32'(blk_in_ready_o), 0);
    #2;
    reset_n     = 1'b1;
    blk_cycle_i = 1'b0;
    tick();
    chk("post_rst_sel", 32'(sel_o), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
